// File: rtl/sha256_job_arbiter.sv
// Round-robin front end that shares one SHA-256 core among NREQ byte-stream requesters.
// Define SHA_ARB_STATS_EN to add the jobs_done / gather_stall statistics outputs.
module sha256_job_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      in_valid,
   input  logic [8*NREQ-1:0]    in_data,
   output logic [NREQ-1:0]      in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDW-1:0]       out_id,
   output logic [255:0]         out_digest,
   output logic                 busy,
   output logic                 core_load,
   output logic [7:0]           core_msg,
   input  logic [15:0]          core_hash
`ifdef SHA_ARB_STATS_EN
   ,
   output logic [15:0]          jobs_done,
   output logic [15:0]          gather_stall
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_GATHER, S_LOAD, S_FEED, S_WAIT, S_COLLECT, S_DONE
   } state_t;

   state_t              r_state;
   logic [IDW-1:0]      r_gnt, r_last, r_id, w_pick;
   logic [NREQ-1:0]     r_in_ready, w_pick_oh;
   logic                w_any, w_vsel;
   logic [7:0]          w_dsel, w_byte, r_core_msg;
   logic [5:0]          r_n;
   logic [6:0]          r_c;
   logic [511:0]        r_buf;
   logic [255:0]        r_digest;
   logic                r_out_valid, r_busy, r_core_load;
   int                  w_d, w_bd;
`ifdef SHA_ARB_STATS_EN
   logic [15:0]         r_jobs, r_stall;
   assign jobs_done    = r_jobs;
   assign gather_stall = r_stall;
`endif

   // Pick the valid requester nearest after the last grant, wrapping modulo NREQ.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_bd   = NREQ;
      w_d    = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_d = (i + 2 * NREQ - int'(r_last) - 1) % NREQ;
         if (in_valid[i] && (w_d < w_bd)) begin
            w_any  = 1'b1;
            w_bd   = w_d;
            w_pick = IDW'(i);
         end
      end
   end

   always_comb begin
      w_pick_oh = '0;
      w_vsel    = 1'b0;
      w_dsel    = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_pick_oh[i] = (w_pick == IDW'(i));
         if (r_gnt == IDW'(i)) begin
            w_vsel = in_valid[i];
            w_dsel = in_data[8*i +: 8];
         end
      end
   end

   // In LOAD (c=0) and FEED (c=1..63) this is the byte due on core_msg next cycle.
   assign w_byte = r_buf[{~r_c[5:0], 3'b111} -: 8];

   always_ff @(posedge clk) begin
      if (r_state == S_GATHER && w_vsel)
         r_buf[{~r_n, 3'b111} -: 8] <= w_dsel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_last      <= IDW'(NREQ - 1);
         r_id        <= '0;
         r_in_ready  <= '0;
         r_n         <= '0;
         r_c         <= '0;
         r_digest    <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_core_load <= 1'b0;
         r_core_msg  <= '0;
`ifdef SHA_ARB_STATS_EN
         r_jobs      <= '0;
         r_stall     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_pick;
                  r_id       <= w_pick;
                  r_last     <= w_pick;
                  r_in_ready <= w_pick_oh;
                  r_busy     <= 1'b1;
                  r_digest   <= '0;
                  r_n        <= '0;
                  r_state    <= S_GATHER;
               end
            end
            S_GATHER: begin
               if (w_vsel) begin
                  r_n <= r_n + 6'd1;
                  if (r_n == 6'd63) begin
                     r_in_ready  <= '0;
                     r_core_load <= 1'b1;
                     r_c         <= '0;
                     r_state     <= S_LOAD;
                  end
               end
`ifdef SHA_ARB_STATS_EN
               if (!w_vsel && r_stall != 16'hFFFF)
                  r_stall <= r_stall + 16'd1;
`endif
            end
            S_LOAD: begin
               r_core_load <= 1'b0;
               r_core_msg  <= w_byte;
               r_c         <= r_c + 7'd1;
               r_state     <= S_FEED;
            end
            S_FEED: begin
               r_c <= r_c + 7'd1;
               if (r_c == 7'd64) begin
                  r_core_msg <= '0;
                  r_state    <= S_WAIT;
               end else begin
                  r_core_msg <= w_byte;
               end
            end
            S_WAIT: begin
               r_c <= r_c + 7'd1;
               if (r_c == 7'd97)
                  r_state <= S_COLLECT;
            end
            S_COLLECT: begin
               r_c      <= r_c + 7'd1;
               r_digest <= {r_digest[239:0], core_hash};
               if (r_c == 7'd113) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
`ifdef SHA_ARB_STATS_EN
                  r_jobs      <= r_jobs + 16'd1;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_id     = r_id;
   assign out_digest = r_digest;
   assign busy       = r_busy;
   assign core_load  = r_core_load;
   assign core_msg   = r_core_msg;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
module tb_sha256_job_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     in_valid;
  logic [8*NREQ-1:0]   in_data;
  logic [NREQ-1:0]     in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [IDW-1:0]      out_id;
  logic [255:0]        out_digest;
  logic                busy;
  logic                core_load;
  logic [7:0]          core_msg;
  logic [15:0]         core_hash;
`ifdef SHA_ARB_STATS_EN
  logic [15:0]         jobs_done;
  logic [15:0]         gather_stall;
`endif

  always #5 clk = ~clk;

  sha256_job_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_digest(out_digest), .busy(busy),
    .core_load(core_load), .core_msg(core_msg), .core_hash(core_hash)
`ifdef SHA_ARB_STATS_EN
    , .jobs_done(jobs_done), .gather_stall(gather_stall)
`endif
  );

  function automatic logic [7:0] blk_byte(input int k);
    logic [511:0] b;
    b = ABC_BLK;
    if (k < 0 || k > 63) return 8'h00;
    return b[511-8*k -: 8];
  endfunction

  function automatic logic [15:0] dig_word(input int j);
    logic [255:0] d;
    d = ABC_DIG;
    return d[255-16*j -: 16];
  endfunction

  int            sc;
  logic [511:0]  rx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= -1;
      rx <= '0;
    end else begin
      if (core_load) sc <= 1;
      else if (sc >= 1 && sc < 120) sc <= sc + 1;
      else sc <= -1;
      if (sc >= 1 && sc <= 64) rx <= {rx[503:0], core_msg};
    end
  end
  assign core_hash = (sc >= 98 && sc <= 113) ?
                     ((rx === ABC_BLK) ? dig_word(sc - 98) : ~dig_word(sc - 98)) : 16'hDEAD;

  int               ncheck = 0, nfail = 0, cycnum = 0;
  int               ptr [NREQ];
  logic [NREQ-1:0]  en, tog, s_rdy, s_hs, rdy_seen;
  logic             phase;
  logic             s_ov, s_busy, s_load;
  logic [255:0]     s_dig, ref_dig;
  logic [IDW-1:0]   s_id, ref_id;
  int               acc_cnt, first_acc, last_acc, ov_cyc;
  logic             ok_ov, ok_dig, ok_id, ok_busy, ok_rdy;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncheck++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      in_valid[r]       = en[r] && (ptr[r] < 64) && (!tog[r] || phase);
      in_data[8*r +: 8] = blk_byte(ptr[r]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    s_rdy  = in_ready;
    s_hs   = in_valid & in_ready;
    s_ov   = out_valid;
    s_busy = busy;
    s_load = core_load;
    s_dig  = out_digest;
    s_id   = out_id;
    rdy_seen |= in_ready;
    if (s_ov && ov_cyc < 0) ov_cyc = cycnum;
    for (int r = 0; r < NREQ; r++) begin
      if (s_hs[r]) begin
        ptr[r]++;
        acc_cnt++;
        if (first_acc < 0) first_acc = cycnum;
        last_acc = cycnum;
      end
    end
    @(posedge clk);
    #1;
    cycnum++;
    phase = ~phase;
    drive();
  endtask

  task automatic clear_obs();
    acc_cnt   = 0;
    first_acc = -1;
    last_acc  = -1;
    ov_cyc    = -1;
    rdy_seen  = '0;
  endtask

  task automatic wait_ov(input int bound);
    int k;
    k = 0;
    while (ov_cyc < 0 && k < bound) begin
      cyc();
      k++;
    end
    chk("out_valid_within_bound", (ov_cyc >= 0), 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = '0;
    tog       = '0;
    out_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) ptr[r] = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    en        = '0;
    tog       = '0;
    phase     = 1'b0;
    for (int r = 0; r < NREQ; r++) ptr[r] = 0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_id", out_id, 2'd0);
    chk("rst_out_digest", out_digest, 256'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_load", core_load, 1'b0);
    chk("rst_core_msg", core_msg, 8'h00);
`ifdef SHA_ARB_STATS_EN
    chk("rst_jobs_done", jobs_done, 16'd0);
    chk("rst_gather_stall", gather_stall, 16'd0);
`endif
    rst = 1'b0;

    clear_obs();
    en[0] = 1'b1; out_ready = 1'b1; drive();
    wait_ov(400);
    chk("abc_bytes", acc_cnt, 64);
    chk("abc_latency", ov_cyc - last_acc, 115);
    chk("abc_digest", s_dig, ABC_DIG);
    chk("abc_id", s_id, 2'd0);
    cyc();
    chk("abc_valid_one_cycle", s_ov, 1'b0);
    chk("abc_busy_back_idle", s_busy, 1'b0);

    do_reset();
    clear_obs();
    en[1] = 1'b1; en[2] = 1'b1; out_ready = 1'b1; drive();
    wait_ov(400);
    chk("rr1_id", s_id, 2'd1);
    chk("rr1_digest", s_dig, ABC_DIG);
    chk("rr1_ready_seen", rdy_seen, 4'b0010);
    chk("rr1_latency", ov_cyc - last_acc, 115);
    clear_obs();
    wait_ov(400);
    chk("rr2_id", s_id, 2'd2);
    chk("rr2_digest", s_dig, ABC_DIG);
    chk("rr2_ready_seen", rdy_seen, 4'b0100);
`ifdef SHA_ARB_STATS_EN
    chk("rr_jobs_done", jobs_done, 16'd2);
`endif

    do_reset();
    clear_obs();
    en[3] = 1'b1; tog[3] = 1'b1; out_ready = 1'b1; drive();
    wait_ov(600);
    chk("stall_bytes", acc_cnt, 64);
    chk("stall_span", last_acc - first_acc, 126);
    chk("stall_digest", s_dig, ABC_DIG);
    chk("stall_id", s_id, 2'd3);
`ifdef SHA_ARB_STATS_EN
    chk("stall_count", gather_stall, 16'd64);
`endif

    do_reset();
    clear_obs();
    en[0] = 1'b1; out_ready = 1'b0; drive();
    wait_ov(400);
    chk("bp_digest", s_dig, ABC_DIG);
    chk("bp_id", s_id, 2'd0);
    en[1] = 1'b1; drive();
    ref_dig = s_dig; ref_id = s_id;
    ok_ov = 1'b1; ok_dig = 1'b1; ok_id = 1'b1; ok_busy = 1'b1; ok_rdy = 1'b1;
    repeat (20) begin
      cyc();
      ok_ov   &= s_ov;
      ok_dig  &= (s_dig === ref_dig);
      ok_id   &= (s_id === ref_id);
      ok_busy &= s_busy;
      ok_rdy  &= (s_rdy === 4'b0000);
    end
    chk("bp_valid_held", ok_ov, 1'b1);
    chk("bp_digest_held", ok_dig, 1'b1);
    chk("bp_id_held", ok_id, 1'b1);
    chk("bp_busy_held", ok_busy, 1'b1);
    chk("bp_no_grant", ok_rdy, 1'b1);
    out_ready = 1'b1;
    cyc();
    chk("bp_hs_valid", s_ov, 1'b1);
    chk("bp_hs_ready", s_rdy, 4'b0000);
    cyc();
    chk("bp_idle_valid", s_ov, 1'b0);
    chk("bp_idle_busy", s_busy, 1'b0);
    chk("bp_idle_ready", s_rdy, 4'b0000);
    cyc();
    chk("bp_next_grant", s_rdy, 4'b0010);
    chk("bp_next_busy", s_busy, 1'b1);

    do_reset();
    clear_obs();
    en[2] = 1'b1; out_ready = 1'b1; drive();
    begin
      int k;
      k = 0;
      s_load = 1'b0;
      while (!s_load && k < 200) begin
        cyc();
        k++;
      end
    end
    chk("rf_load_seen", s_load, 1'b1);
    repeat (29) cyc();
    chk("rf_pre_busy", busy, 1'b1);
    chk("rf_pre_id", out_id, 2'd2);
    rst = 1'b1;
    #1;
    chk("rf_in_ready", in_ready, 4'b0000);
    chk("rf_out_valid", out_valid, 1'b0);
    chk("rf_out_id", out_id, 2'd0);
    chk("rf_out_digest", out_digest, 256'h0);
    chk("rf_busy", busy, 1'b0);
    chk("rf_core_load", core_load, 1'b0);
    chk("rf_core_msg", core_msg, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ptr[2] = 0;
    clear_obs();
    drive();
    wait_ov(400);
    chk("rf_new_bytes", acc_cnt, 64);
    chk("rf_new_latency", ov_cyc - last_acc, 115);
    chk("rf_new_digest", s_dig, ABC_DIG);
    chk("rf_new_id", s_id, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
